dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-requester arbiter that shares the processor's single-port data memory (`datmem`) between the CPU load/store path and a debug/loader port. The debug/loader port initialises and inspects memory in place of bench-side `$readmemh` pokes. The block sits between `processor` and the data-memory array and owns all memory enables. Requests use a req/ack handshake. Ownership alternates round-robin. Reads account for the memory's one-cycle synchronous read latency.

## Interface
Parameters:
- AW, 5, word-address width (32 words)
- DW, 32, data width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- c_req  in  1  CPU request; held until c_ack
- c_we  in  1  CPU write (1) / read (0)
- c_addr  in  AW  CPU word address
- c_wdata  in  DW  CPU write data
- c_ack  out  1  CPU transaction-complete pulse
- c_rdata  out  DW  CPU read data; valid when c_ack and read
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  debug port request, same meaning as c_*
- d_ack, d_rdata  out  1/DW  debug port completion and read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after a read strobe
- busy  out  1  arbiter not in IDLE
- owner  out  1  0 = CPU, 1 = debug; meaningful while busy

## Operation
- States:
  - IDLE: waits for a request.
  - ACCESS: drives the memory strobe.
  - RDWAIT: waits for read data.
- IDLE, any unmasked req at edge → latch winner id, we, addr, wdata into internal registers → ACCESS.
- Winner selection:
  - Only one req: that requester wins.
  - Both req: the requester not granted last wins.
  - After reset, "last granted" = debug, so the CPU wins the first tie.
- ACCESS:
  - mem_en=1; mem_we, mem_addr, mem_wdata come from the latched registers.
  - Write: the owner's ack=1 this cycle → IDLE.
  - Read: → RDWAIT.
- RDWAIT: owner's ack=1, owner's rdata=mem_rdata → IDLE.
- Requester inputs are latched at grant. Changes to addr/we/wdata, or dropping req, after grant are ignored. The latched transaction always completes and acks.
- Ack-edge masking: on the edge closing an ack cycle, the acked requester's req is ignored for one cycle. This prevents a duplicate grant. A requester may issue its next transaction by holding or raising req after that cycle.
- Non-owner ack stays 0. Rdata outputs hold their last value when ack=0.
- mem_we is asserted only together with mem_en.

## Timing
- Reset values: state IDLE, all acks 0, mem_en 0, mem_we 0, busy 0, owner 0, rdata 0, last-granted = debug.
- Write latency: req sampled at edge N → ACCESS and ack in cycle N+1 → memory written at edge N+1/N+2 boundary.
- Read latency: req at edge N → strobe in N+1 → ack and data in N+2.
- Idle cycles:
  - One mandatory IDLE cycle follows every transaction.
  - Throughput: one write per 2 cycles, one read per 3 cycles.
- Simultaneous req in IDLE: exactly one grant, round-robin. The loser stays pending and is granted at the next IDLE edge.
- Reset mid-operation:
  - Reset high at any edge → IDLE next cycle, no further ack.
  - A write whose ACCESS cycle coincides with reset high is still strobed and acked.
  - A read in ACCESS or RDWAIT is dropped without ack.
- Address wrap is not handled: addresses are used as given (AW bits).

## Structure
- Shared package `dmem_arb_pkg`:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RDWAIT=2'd2)
  - requester ids (REQ_CPU=1'b0, REQ_DBG=1'b1)
- One sub-module `rr_pick2`: 2-way round-robin selector.
  - Inputs: masked requests, last-granted id.
  - Outputs: grant_valid, grant_id.
  - Purely combinational.
- All state, latches and outputs are registered, or decoded from state in the top module.

## Test plan
- CPU write, then read, with debug idle: c_req, c_we=1, c_addr=5'h03, c_wdata=32'hDEADBEEF.
  - Required: mem_en and mem_we for one cycle at addr 3, c_ack in the next cycle.
  - Follow-up read of addr 3: c_ack two cycles after grant, c_rdata=32'hDEADBEEF.
- Simultaneous first requests: c_req and d_req both high from reset release.
  - Required: CPU granted first (owner=0), debug next (owner=1); d_ack never coincides with c_ack.
- Both requesters held high for 8 transactions.
  - Required: grants strictly alternate 0,1,0,1…; each ack is followed by exactly one IDLE cycle.
- Inputs changed after grant: d_addr changed from 5'h07 to 5'h09 and d_req dropped one cycle after grant.
  - Required: memory strobed at addr 7; d_ack still pulses once.
- Reset during read: reset high in the RDWAIT cycle of a CPU read.
  - Required: no c_ack; busy=0 and mem_en=0 the next cycle.
  - Next request: served normally, with CPU winning the tie.
- Single requester back-to-back: d_req held high for 3 writes.
  - Required: exactly 3 d_acks spaced 2 cycles apart; no duplicate strobe.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory port arbiter:
//   arb_state_e : arbiter FSM encoding (IDLE / ACCESS / RDWAIT)
//   req_id_e    : requester identity (CPU load/store path or debug/loader)
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin selector, purely combinational.
// Ports:
//   i_req[1:0]    in   masked requests, bit 0 = CPU, bit 1 = debug
//   i_last        in   requester granted most recently
//   o_grant_valid out  at least one request present
//   o_grant_id    out  winning requester
// ---------------------------------------------------------------------------
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_e    i_last,
    output logic       o_grant_valid,
    output req_id_e    o_grant_id
);

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        o_grant_valid = |i_req;
        o_grant_id    = REQ_CPU;
        if (i_req == 2'b11) begin
            // Tie: whoever was not served last goes next.
            o_grant_id = (i_last == REQ_DBG) ? REQ_CPU : REQ_DBG;
        end else if (i_req[1]) begin
            o_grant_id = REQ_DBG;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single-port data memory between the CPU load/store path (c_*)
// and the debug/loader port (d_*). Round-robin ownership, req/ack handshake,
// one-cycle synchronous read latency, one IDLE cycle after every transaction.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata        CPU request (held until c_ack)
//   c_ack/c_rdata                    CPU completion pulse / read data
//   d_req/d_we/d_addr/d_wdata        debug request, same meaning
//   d_ack/d_rdata                    debug completion pulse / read data
//   mem_en/mem_we/mem_addr/mem_wdata memory strobe, write enable, address, data
//   mem_rdata                        memory read data, one cycle after strobe
//   busy                             arbiter not in IDLE
//   owner                            0 = CPU, 1 = debug (meaningful while busy)
// ---------------------------------------------------------------------------
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    req_id_e       r_owner;
    req_id_e       r_last;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_c_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_done;
    logic [1:0]    w_req;
    logic          w_grant_valid;
    req_id_e       w_grant_id;
    logic          w_grant;

    // A requester whose ack is showing is masked so the edge closing its ack
    // can never hand it a second grant for the same request.
    assign w_req   = {d_req & ~d_ack, c_req & ~c_ack};
    assign w_grant = (r_state == IDLE) && w_grant_valid;

    rr_pick2 u_pick (
        .i_req         (w_req),
        .i_last        (r_last),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) w_state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = r_we;
                if (r_we) begin
                    // A write is complete once strobed, even if reset is
                    // already asserted in this cycle.
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RDWAIT;
                end
            end
            RDWAIT: begin
                // A read caught by reset is dropped without an ack.
                w_done      = ~reset;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign c_ack     = w_done && (r_owner == REQ_CPU);
    assign d_ack     = w_done && (r_owner == REQ_DBG);
    // Read data passes straight through in the ack cycle, then holds.
    assign c_rdata   = (c_ack && !r_we) ? mem_rdata : r_c_rdata;
    assign d_rdata   = (d_ack && !r_we) ? mem_rdata : r_d_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != IDLE);
    assign owner     = r_owner;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_owner   <= REQ_CPU;
            r_last    <= REQ_DBG;
            r_c_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_grant_id;
                r_last  <= w_grant_id;
            end
            if (c_ack && !r_we) r_c_rdata <= mem_rdata;
            if (d_ack && !r_we) r_d_rdata <= mem_rdata;
        end
    end

    // NOTE: the latched transaction needs no reset; it is only consumed in
    // ACCESS/RDWAIT, which are reachable only after a grant has loaded it.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            if (w_grant_id == REQ_DBG) begin
                r_we    <= d_we;
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
            end else begin
                r_we    <= c_we;
                r_addr  <= c_addr;
                r_wdata <= c_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Transaction-level reference model (cycles-remaining per transaction, a
// scoreboard memory, round-robin bookkeeping) compared against the DUT on
// every cycle, plus directed scenarios with hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          c_ack;
    logic [DW-1:0] c_rdata;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy, owner;

    dmem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Data memory stand-in: synchronous single port, one-cycle read latency.
    logic [DW-1:0] env_mem [32];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    int            cyc = 0;
    bit            m_valid = 0;
    int            m_left = 0;      // busy cycles left in current transaction
    bit            m_first = 0;     // current cycle is the strobe cycle
    bit            m_we = 0;
    bit            m_own = 0;
    bit            m_last = 1;      // last granted, debug after reset
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_crd = '0, m_drd = '0;
    logic [DW-1:0] mmem [32];

    always @(posedge clk) begin : model
        bit ack_now;
        bit win;
        cyc++;
        ack_now = (m_left == 1) && (m_we || !reset);
        if (m_left > 0 && m_first && m_we) mmem[m_addr] = m_wdata;
        if (ack_now && !m_we) begin
            if (m_own) m_drd = mmem[m_addr];
            else       m_crd = mmem[m_addr];
        end
        if (reset) begin
            m_left = 0; m_first = 0; m_own = 0; m_last = 1;
            m_crd = '0; m_drd = '0; m_valid = 1;
        end else if (m_left > 0) begin
            m_left--;
            m_first = 0;
        end else if (c_req || d_req) begin
            win     = (c_req && d_req) ? !m_last : d_req;
            m_we    = win ? d_we : c_we;
            m_addr  = win ? d_addr : c_addr;
            m_wdata = win ? d_wdata : c_wdata;
            m_left  = m_we ? 1 : 2;
            m_first = 1;
            m_own   = win;
            m_last  = win;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sampled snapshot and logs
    logic          s_busy, s_mem_en, s_c_ack, s_d_ack, s_owner;
    logic [DW-1:0] s_c_rdata, s_d_rdata;
    int            strobe_cnt = 0, c_ack_cnt = 0, d_ack_cnt = 0, idle_cnt = 0, both_ack_cnt = 0;
    logic [AW-1:0] last_strobe_addr = '0;
    logic          last_strobe_we = 1'b0;
    bit            owner_q [$];
    int            c_ack_cyc [$];
    int            d_ack_cyc [$];

    task automatic observe();
        logic          e_ack, e_strobe;
        logic [DW-1:0] e_crd, e_drd;
        @(negedge clk);
        s_busy = busy; s_mem_en = mem_en; s_c_ack = c_ack; s_d_ack = d_ack;
        s_owner = owner; s_c_rdata = c_rdata; s_d_rdata = d_rdata;
        if (m_valid) begin
            e_ack    = (m_left == 1) && (m_we || !reset);
            e_strobe = (m_left > 0) && m_first;
            e_crd    = (e_ack && !m_we && !m_own) ? mmem[m_addr] : m_crd;
            e_drd    = (e_ack && !m_we &&  m_own) ? mmem[m_addr] : m_drd;
            check("busy", busy, m_left > 0);
            if (m_left > 0) check("owner", owner, m_own);
            check("mem_en", mem_en, e_strobe);
            check("mem_we", mem_we, e_strobe && m_we);
            if (e_strobe) begin
                check("mem_addr", mem_addr, m_addr);
                if (m_we) check("mem_wdata", mem_wdata, m_wdata);
            end
            check("c_ack", c_ack, e_ack && !m_own);
            check("d_ack", d_ack, e_ack && m_own);
            check("c_rdata", c_rdata, e_crd);
            check("d_rdata", d_rdata, e_drd);
        end
        if (mem_en) begin
            strobe_cnt++;
            owner_q.push_back(owner);
            last_strobe_addr = mem_addr;
            last_strobe_we   = mem_we;
        end
        if (c_ack) begin c_ack_cnt++; c_ack_cyc.push_back(cyc); end
        if (d_ack) begin d_ack_cnt++; d_ack_cyc.push_back(cyc); end
        if (c_ack && d_ack) both_ack_cnt++;
        if (!busy) idle_cnt++;
    endtask

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        observe();
        drive_point();
    endtask

    // Hold each request for nc / nd transactions; after every ack the
    // requester moves to the next address and data.
    task automatic run_both(input int nc, input int nd);
        c_req = (nc > 0);
        d_req = (nd > 0);
        for (int k = 0; k < 300 && (nc > 0 || nd > 0); k++) begin
            observe();
            if (s_c_ack) begin nc--; c_addr = c_addr + 1'b1; c_wdata = c_wdata + 32'h0101_0101; end
            if (s_d_ack) begin nd--; d_addr = d_addr + 1'b1; d_wdata = d_wdata + 32'h0101_0101; end
            drive_point();
            c_req = (nc > 0);
            d_req = (nd > 0);
        end
        check("run_complete", nc + nd, 0);
    endtask

    int t0, b_str, b_cack, b_dack, b_idle, n;

    initial begin
        // Reset state
        repeat (3) cycle();
        check("rst_busy", s_busy, 1'b0);
        check("rst_mem_en", s_mem_en, 1'b0);
        check("rst_c_ack", s_c_ack, 1'b0);
        check("rst_d_ack", s_d_ack, 1'b0);
        check("rst_owner", s_owner, 1'b0);
        check("rst_c_rdata", s_c_rdata, 32'h0);
        check("rst_d_rdata", s_d_rdata, 32'h0);
        reset = 1'b0;
        cycle();

        // 1: CPU write then read of address 3
        c_we = 1'b1; c_addr = 5'h03; c_wdata = 32'hDEAD_BEEF;
        t0 = cyc; b_str = strobe_cnt;
        run_both(1, 0);
        check("wr_latency", c_ack_cyc[$] - t0, 1);
        check("wr_strobes", strobe_cnt - b_str, 1);
        check("wr_addr", last_strobe_addr, 5'h03);
        check("wr_we", last_strobe_we, 1'b1);
        cycle();
        c_we = 1'b0; c_addr = 5'h03;
        t0 = cyc;
        run_both(1, 0);
        check("rd_latency", c_ack_cyc[$] - t0, 2);
        check("rd_data", s_c_rdata, 32'hDEAD_BEEF);
        cycle();

        // 2: simultaneous requests from reset release
        reset = 1'b1;
        c_we = 1'b1; c_addr = 5'h01; c_wdata = 32'h1111_1111; c_req = 1'b1;
        d_we = 1'b1; d_addr = 5'h02; d_wdata = 32'h2222_2222; d_req = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
        owner_q.delete();
        run_both(1, 1);
        check("tie_grants", owner_q.size(), 2);
        if (owner_q.size() == 2) begin
            check("tie_first_cpu", owner_q[0], 1'b0);
            check("tie_second_dbg", owner_q[1], 1'b1);
        end
        cycle();

        // 3: both held for 8 writes
        c_addr = 5'h10; c_wdata = 32'h1000_0000;
        d_addr = 5'h06; d_wdata = 32'hA000_0000;
        owner_q.delete();
        t0 = cyc; b_idle = idle_cnt;
        run_both(4, 4);
        check("rr_grants", owner_q.size(), 8);
        for (int i = 0; i < 8 && i < owner_q.size(); i++)
            check("rr_alternate", owner_q[i], i[0]);
        check("rr_idle_cycles", idle_cnt - b_idle, 8);
        check("rr_span", d_ack_cyc[$] - t0, 15);
        check("rr_no_dual_ack", both_ack_cnt, 0);
        cycle();

        // 4: inputs change / req drops right after grant (read of addr 7)
        d_we = 1'b0; d_addr = 5'h07; d_req = 1'b1;
        b_str = strobe_cnt; b_dack = d_ack_cnt;
        cycle();
        d_addr = 5'h09; d_req = 1'b0; d_we = 1'b1; d_wdata = 32'hBAD0_BAD0;
        repeat (6) cycle();
        check("chg_strobes", strobe_cnt - b_str, 1);
        check("chg_addr", last_strobe_addr, 5'h07);
        check("chg_we", last_strobe_we, 1'b0);
        check("chg_acks", d_ack_cnt - b_dack, 1);
        check("chg_rdata", s_d_rdata, 32'hA101_0101);

        // 5: reset in RDWAIT of a CPU read
        c_we = 1'b0; c_addr = 5'h03; c_req = 1'b1;
        b_cack = c_ack_cnt;
        cycle();          // IDLE, grant on closing edge
        cycle();          // ACCESS
        reset = 1'b1;
        cycle();          // RDWAIT under reset
        check("rstrd_no_ack", s_c_ack, 1'b0);
        reset = 1'b0; c_req = 1'b0;
        cycle();
        check("rstrd_busy", s_busy, 1'b0);
        check("rstrd_mem_en", s_mem_en, 1'b0);
        check("rstrd_ack_cnt", c_ack_cnt - b_cack, 0);
        c_we = 1'b1; c_addr = 5'h04; c_wdata = 32'h4444_4444;
        d_we = 1'b1; d_addr = 5'h05; d_wdata = 32'h5555_5555;
        owner_q.delete();
        run_both(1, 1);
        if (owner_q.size() > 0) check("rstrd_cpu_first", owner_q[0], 1'b0);
        else check("rstrd_grants", owner_q.size(), 2);
        cycle();

        // 6: single requester, three back-to-back writes
        d_we = 1'b1; d_addr = 5'h18; d_wdata = 32'h6666_6666;
        b_str = strobe_cnt; b_dack = d_ack_cnt;
        run_both(0, 3);
        check("b2b_strobes", strobe_cnt - b_str, 3);
        check("b2b_acks", d_ack_cnt - b_dack, 3);
        n = d_ack_cyc.size();
        if (n >= 3) begin
            check("b2b_gap1", d_ack_cyc[n-2] - d_ack_cyc[n-3], 2);
            check("b2b_gap2", d_ack_cyc[n-1] - d_ack_cyc[n-2], 2);
        end
        cycle();

        // 7: interleaved reads from both ports
        c_we = 1'b0; c_addr = 5'h11;
        d_we = 1'b0; d_addr = 5'h19;
        t0 = cyc;
        run_both(2, 1);
        check("rd_span", c_ack_cyc[$] - t0, 8);
        check("rd_c_last", s_c_rdata, 32'h1202_0202);
        check("rd_d_hold", s_d_rdata, 32'h6767_6767);
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
